// File: rtl/ram_arb.sv
// ram_arb: time-slices a 16x8 single-port RAM between the CPU and an external program loader.
// Owns the CPU MAR and stalls the CPU while the loader holds the RAM.
module ram_arb #(
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned CPU_SLOTS = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cu_mi,
   input  logic       cu_ri,
   input  logic       cu_ro,
   input  logic       cu_h,
   input  logic [7:0] cpu_bus,
   output logic [7:0] cpu_rdata,
   output logic       cpu_stall,
   input  logic       ld_req,
   input  logic [3:0] ld_addr,
   input  logic       ld_we,
   input  logic [7:0] ld_wdata,
   output logic       ld_gnt,
   output logic [7:0] ld_rdata,
   output logic [3:0] ram_addr,
   output logic       ram_we,
   output logic [7:0] ram_wdata,
   input  logic [7:0] ram_rdata,
   output logic       bus_err
);

   typedef enum logic [1:0] {S_CPU, S_LDR, S_HOLD} state_t;

   localparam logic [3:0] BCNT_LAST = 4'(MAX_BURST - 1);
   localparam logic [3:0] HCNT_LAST = 4'(CPU_SLOTS - 1);

   state_t     state_q, state_d;
   logic [3:0] mar_q, mar_d;
   logic [3:0] bcnt_q, bcnt_d;
   logic [3:0] hcnt_q, hcnt_d;
   logic       bus_err_q, bus_err_d;
   logic       gnt_q, gnt_d;
   logic       cpu_own;

   assign cpu_own = (state_q != S_LDR);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d   = state_q;
      mar_d     = mar_q;
      bcnt_d    = bcnt_q;
      hcnt_d    = hcnt_q;
      bus_err_d = bus_err_q;

      if (cpu_own) begin
         if (cu_mi)
            mar_d = cpu_bus[3:0];
         if (cu_ri && cu_ro)
            bus_err_d = 1'b1;
      end

      case (state_q)
         S_CPU: begin
            if (ld_req) begin
               state_d = S_LDR;
               bcnt_d  = '0;
            end
         end
         S_LDR: begin
            if (!ld_req) begin
               state_d = S_CPU;
            end else begin
               // Saturate so a long halted burst cannot wrap and dodge the cut once cu_h drops.
               if (bcnt_q != 4'hF)
                  bcnt_d = bcnt_q + 4'd1;
               if (!cu_h && bcnt_q >= BCNT_LAST) begin
                  state_d = S_HOLD;
                  hcnt_d  = '0;
               end
            end
         end
         S_HOLD: begin
            hcnt_d = hcnt_q + 4'd1;
            if (hcnt_q == HCNT_LAST) begin
               if (ld_req) begin
                  state_d = S_LDR;
                  bcnt_d  = '0;
               end else begin
                  state_d = S_CPU;
               end
            end
         end
         default: state_d = S_CPU;
      endcase
   end

   // Grant/stall come straight from a flop so the CU never sees a decode glitch.
   assign gnt_d = (state_d == S_LDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_CPU;
         mar_q     <= '0;
         bcnt_q    <= '0;
         hcnt_q    <= '0;
         bus_err_q <= 1'b0;
         gnt_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         state_q   <= state_d;
         mar_q     <= mar_d;
         bcnt_q    <= bcnt_d;
         hcnt_q    <= hcnt_d;
         bus_err_q <= bus_err_d;
         gnt_q     <= gnt_d;
      end
   end

   always_comb begin
      ram_addr  = mar_q;
      ram_we    = cu_ri;
      ram_wdata = cpu_bus;
      if (!cpu_own) begin
         ram_addr  = ld_addr;
         ram_we    = ld_req & ld_we;
         ram_wdata = ld_wdata;
      end
      // A write must not slip through while reset holds the arbiter.
      if (!rst_n)
         ram_we = 1'b0;
   end

   assign cpu_stall = gnt_q;
   assign ld_gnt    = gnt_q;
   assign cpu_rdata = ram_rdata;
   assign ld_rdata  = ram_rdata;
   assign bus_err   = bus_err_q;

endmodule
